// File: rtl/dmem_loader_ctrl.sv
// Host loader: streams a byte image into data-memory port 0, starts the cores,
// waits for every end-of-program flag, then streams a result window back out.
module dmem_loader_ctrl #(
  parameter int                    reg_width    = 12,
  parameter int                    addr_width   = 12,
  parameter int                    core_count   = 2,
  parameter int                    load_count   = 256,
  parameter logic [addr_width-1:0] result_base  = 12'h100,
  parameter int                    result_count = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [addr_width-1:0] mem_address,
  output logic [reg_width-1:0]  mem_datain,
  output logic                  mem_write,
  input  logic [reg_width-1:0]  mem_dataout,
  output logic                  mem_owner,
  output logic                  start,
  input  logic [core_count-1:0] endop_signal,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = addr_width + 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(load_count - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(result_count - 1);

  typedef enum logic [3:0] {
    S_LOAD_LO,
    S_LOAD_HI,
    S_WRITE,
    S_START,
    S_RUN,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_LO,
    S_TX_HI,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [addr_width-1:0]   r_addr;
  logic [CW-1:0]           r_cnt;
  logic [reg_width-1:0]    r_word;
  logic                    r_run_armed;

  state_t                  w_state_nxt;
  logic [addr_width-1:0]   w_addr_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [reg_width-1:0]    w_word_nxt;
  logic                    w_armed_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD_LO;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_word      <= '0;
      r_run_armed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_word      <= w_word_nxt;
      r_run_armed <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_armed_nxt = r_run_armed;
    rx_ready    = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    mem_write   = 1'b0;
    mem_address = r_addr;
    mem_datain  = '0;
    mem_owner   = 1'b1;
    start       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    case (r_state)
      S_LOAD_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          w_word_nxt[7:0] = rx_data;
          w_state_nxt     = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        rx_ready = 1'b1;
        // Truncating cast drops the high-byte bits that do not fit the word.
        if (rx_valid) begin
          w_word_nxt  = reg_width'({rx_data, r_word[7:0]});
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_write  = 1'b1;
        mem_datain = r_word;
        w_addr_nxt = r_addr + 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        w_state_nxt = (r_cnt == LOAD_LAST) ? S_START : S_LOAD_LO;
      end
      S_START: begin
        start       = 1'b1;
        mem_owner   = 1'b0;
        w_armed_nxt = 1'b0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // First RUN cycle only arms the check, masking flags left from a prior run.
        mem_owner   = 1'b0;
        w_armed_nxt = 1'b1;
        if (r_run_armed && (&endop_signal)) begin
          w_addr_nxt  = result_base;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_word_nxt  = mem_dataout;
        w_state_nxt = S_TX_LO;
      end
      S_TX_LO: begin
        tx_valid = 1'b1;
        tx_data  = r_word[7:0];
        if (tx_ready) w_state_nxt = S_TX_HI;
      end
      S_TX_HI: begin
        tx_valid = 1'b1;
        tx_data  = 8'(r_word >> 8);
        if (tx_ready) begin
          w_addr_nxt  = r_addr + 1'b1;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = (r_cnt == RES_LAST) ? S_DONE : S_RD_ADDR;
        end
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: w_state_nxt = S_LOAD_LO;
    endcase

    // Outputs take their idle values for the whole reset cycle, not one edge later.
    if (reset) begin
      rx_ready    = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = '0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_datain  = '0;
      mem_owner   = 1'b1;
      start       = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_loader_ctrl.sv
// Bench for dmem_loader_ctrl: two instances (short load, full 4096-word load)
// each checked every cycle against a transaction-level model of the loader.
`timescale 1ns/1ps
module tb_dmem_loader_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RW    = 12;
    localparam int AW    = 12;
    localparam int CC    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int LC    = (g == 0) ? 2 : 4096;
    localparam int RB    = (g == 0) ? 'h100 : 'hFFE;
    localparam int RC    = (g == 0) ? 1 : 3;

    logic          reset    = 1'b1;
    logic [7:0]    rx_data  = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] mem_address;
    logic [RW-1:0] mem_datain;
    logic          mem_write;
    logic [RW-1:0] mem_dataout;
    logic          mem_owner;
    logic          start;
    logic [CC-1:0] endop    = '0;
    logic          busy;
    logic          done;
    bit            fin      = 1'b0;

    dmem_loader_ctrl #(
      .reg_width(RW), .addr_width(AW), .core_count(CC), .load_count(LC),
      .result_base(AW'(RB)), .result_count(RC)
    ) u_dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_address(mem_address), .mem_datain(mem_datain), .mem_write(mem_write),
      .mem_dataout(mem_dataout), .mem_owner(mem_owner), .start(start),
      .endop_signal(endop), .busy(busy), .done(done)
    );

    // Port-0 RAM with one-cycle read latency, randomly filled at the first edge
    logic [RW-1:0] ram [DEPTH];
    bit            ram_init = 1'b0;
    bit            pl_en    = 1'b0;
    logic [AW-1:0] pl_addr  = '0;
    logic [RW-1:0] pl_data  = '0;
    always @(posedge clk) begin
      if (!ram_init) begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= RW'($urandom);
        ram_init <= 1'b1;
      end else if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_write) ram[mem_address] <= mem_datain;
      mem_dataout <= ram[mem_address];
    end

    function automatic string nm(input string s);
      return $sformatf("u%0d.%s", g, s);
    endfunction

    function automatic int pack(input int l, input int h);
      return ((h % (1 << (RW - 8))) << 8) | (l & 255);
    endfunction

    // Behavioural model: byte pairs become words, words go to consecutive
    // addresses, then start, run until all flags (not in the first run cycle),
    // then each result word is sent low byte / high byte after a 2-cycle fetch.
    int   wr_cnt = 0, n_wr = 0, n_start = 0, run_cyc = 0, gap = 0, ph = 0, word = 0;
    bit   have_lo = 0, have_word = 0, start_due = 0, running = 0, reading = 0, done_exp = 0;
    logic [7:0] lo = '0;
    int   wq[$];
    logic [7:0] txlog[$];

    initial begin : mdl
      bit start_next;
      forever begin
        @(negedge clk);
        if (reset) begin
          chk(nm("rst_rx_ready"), rx_ready, 0);
          chk(nm("rst_tx_valid"), tx_valid, 0);
          chk(nm("rst_tx_data"), tx_data, 0);
          chk(nm("rst_mem_write"), mem_write, 0);
          chk(nm("rst_mem_address"), mem_address, 0);
          chk(nm("rst_mem_datain"), mem_datain, 0);
          chk(nm("rst_mem_owner"), mem_owner, 1);
          chk(nm("rst_start"), start, 0);
          chk(nm("rst_busy"), busy, 1);
          chk(nm("rst_done"), done, 0);
          wr_cnt = 0; n_wr = 0; n_start = 0; have_lo = 0; have_word = 0;
          start_due = 0; running = 0; reading = 0; done_exp = 0; wq.delete();
        end else begin
          chk(nm("rx_ready"), rx_ready, (wr_cnt < LC) && !have_word);
          chk(nm("mem_write"), mem_write, have_word);
          if (mem_write) begin
            chk(nm("wr_addr"), mem_address, wr_cnt % DEPTH);
            chk(nm("wr_data"), mem_datain, word);
            n_wr++;
          end
          chk(nm("start"), start, start_due);
          if (start) n_start++;
          chk(nm("mem_owner"), mem_owner, !(running || start_due));
          if (reading && gap == 0) begin
            chk(nm("tx_valid"), tx_valid, 1);
            chk(nm("tx_data"), tx_data, ph ? (wq[0] >> 8) : (wq[0] & 255));
          end else begin
            chk(nm("tx_valid"), tx_valid, 0);
          end
          chk(nm("done"), done, done_exp);
          chk(nm("busy"), busy, !done_exp);

          start_next = 1'b0;
          if (have_word) begin
            have_word = 0;
            wr_cnt++;
            start_next = (wr_cnt == LC);
          end
          if (reading) begin
            if (gap > 0) gap--;
            else if (tx_ready) begin
              if (ph == 0) ph = 1;
              else begin
                ph = 0;
                gap = 2;
                void'(wq.pop_front());
                if (wq.size() == 0) begin
                  reading = 0;
                  done_exp = 1;
                end
              end
            end
          end
          if (start_due) begin
            running = 1;
            run_cyc = 0;
          end else if (running) begin
            run_cyc++;
            if (run_cyc >= 2 && (&endop)) begin
              running = 0;
              reading = 1;
              gap = 2;
              ph = 0;
              wq.delete();
              for (int i = 0; i < RC; i++) wq.push_back(int'(ram[(RB + i) % DEPTH]));
            end
          end
          start_due = start_next;
          if (rx_valid && rx_ready) begin
            if (!have_lo) begin
              lo = rx_data;
              have_lo = 1;
            end else begin
              word = pack(lo, rx_data);
              have_lo = 0;
              have_word = 1;
            end
          end
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic do_reset(input int n);
      reset = 1'b1;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int pct);
      int i = 0;
      int guard = 0;
      while (i < b.size() && guard < 20 * b.size() + 200) begin
        rx_data  = b[i];
        rx_valid = ($urandom_range(99) < pct);
        @(negedge clk);
        if (rx_valid && rx_ready) i++;
        tick();
        guard++;
      end
      rx_valid = 1'b0;
      chk(nm("send_timeout"), i, b.size());
    endtask

    // mode 0: flags all set; 1: only bit0 until 20 cycles after start; 2: random
    task automatic finish_run(input int mode, input int txpct, input bit stall,
                              input int abort_at, output int rise);
      int k = -1;
      bit started = 0;
      int stall_n = 0;
      int cyc = 0;
      bit stop = 0;
      rise = -1;
      while (cyc < 3000 && !stop) begin
        if (cyc == abort_at) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          return;
        end
        case (mode)
          0:       endop = '1;
          1:       endop = (!started || k + 1 <= 20) ? 2'b01 : 2'b11;
          default: endop = CC'($urandom);
        endcase
        tx_ready = stall ? (stall_n >= 5) : ($urandom_range(99) < txpct);
        @(negedge clk);
        if (start) begin
          started = 1;
          k = 0;
        end else if (started) k++;
        if (started && rise < 0 && mem_owner && !start) rise = k;
        if (tx_valid) begin
          if (tx_ready) txlog.push_back(tx_data);
          stall_n++;
        end
        stop = done;
        tick();
        cyc++;
      end
      chk(nm("run_timeout"), stop, 1);
    endtask

    if (g == 0) begin : g_drv
      initial begin
        int rise;
        int ab;
        logic [7:0] bq[$];
        endop = '1;
        do_reset(3);
        reset = 1'b1; pl_en = 1'b1; pl_addr = 'h100; pl_data = 'hA5C;
        tick();
        pl_en = 1'b0; reset = 1'b0;

        // Load two words, flags already high, stalled single-word readback
        txlog.delete();
        bq = '{8'h34, 8'hF2, 8'hCD, 8'h0B};
        send_bytes(bq, 100);
        finish_run(0, 100, 1, -1, rise);
        chk(nm("t1_mem0"), ram[0], 'h234);
        chk(nm("t1_mem1"), ram[1], 'hBCD);
        chk(nm("t2_owner_rise"), rise, 3);
        chk(nm("t4_tx_lo"), (txlog.size() > 0) ? int'(txlog[0]) : -1, 'h5C);
        chk(nm("t4_tx_hi"), (txlog.size() > 1) ? int'(txlog[1]) : -1, 'h0A);
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (4) tick();
        rx_valid = 1'b0;

        // One core finishes long before the other
        do_reset(1);
        endop = 2'b01;
        bq.delete();
        repeat (2 * LC) bq.push_back(8'($urandom));
        send_bytes(bq, 60);
        finish_run(1, 70, 0, -1, rise);
        chk(nm("t3_owner_rise"), rise, 22);

        // Reset with half a word received
        do_reset(1);
        endop = '1;
        bq = '{8'h99};
        send_bytes(bq, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bq = '{8'h11, 8'h37, 8'h22, 8'h48};
        send_bytes(bq, 100);
        finish_run(0, 100, 0, -1, rise);
        chk(nm("t5_mem0"), ram[0], 'h711);
        chk(nm("t5_mem1"), ram[1], 'h822);

        for (int r = 0; r < 12; r++) begin
          do_reset(1 + $urandom_range(1));
          endop = CC'($urandom);
          bq.delete();
          repeat (2 * LC) bq.push_back(8'($urandom));
          send_bytes(bq, 30 + $urandom_range(70));
          ab = -1;
          if ($urandom_range(3) == 0) ab = int'($urandom_range(12));
          finish_run(2, 30 + $urandom_range(70), 0, ab, rise);
        end
        fin = 1'b1;
      end
    end else begin : g_drv
      initial begin
        int rise;
        logic [7:0] bq[$];
        endop = '1;
        do_reset(3);
        txlog.delete();
        bq.delete();
        repeat (2 * LC) bq.push_back(8'($urandom));
        send_bytes(bq, 100);
        finish_run(0, 50, 0, -1, rise);
        chk(nm("t6_writes"), n_wr, 4096);
        chk(nm("t6_starts"), n_start, 1);
        chk(nm("t6_last"), ram[12'hFFF], pack(bq[8190], bq[8191]));
        chk(nm("t6_first"), ram[0], pack(bq[0], bq[1]));
        chk(nm("t6_txbytes"), txlog.size(), 6);
        fin = 1'b1;
      end
    end
  end

  initial begin
    int t = 0;
    while (!(g_dut[0].fin && g_dut[1].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("all_finished", g_dut[0].fin && g_dut[1].fin, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
